// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB stage register: write-back control bundle,
// stored entry layout, fill-level FSM encoding and write-back source select.
package mem_wb_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Write-back control bits travelling with each instruction.
  typedef struct packed {
    logic reg_write;
    logic jump_rd;
    logic mem_to_reg;
  } wb_ctrl_t;

  // What an entry keeps once the write-back value has been selected.
  typedef struct packed {
    logic [XLEN_DEF-1:0]       data;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      reg_write;
  } wb_entry_t;

  // Number of entries held by the stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fill_state_t;

  // Write-back value source.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_PC  = 2'd1,
    SRC_MEM = 2'd2
  } wb_src_t;

  // Load data beats link value, link value beats the ALU result.
  function automatic wb_src_t wb_select(input logic mem_to_reg, input logic jump_rd);
    wb_src_t src;
    src = SRC_ALU;
    if (mem_to_reg) begin
      src = SRC_MEM;
    end else if (jump_rd) begin
      src = SRC_PC;
    end
    return src;
  endfunction

endpackage

// File: rtl/mem_wb_stage_register_if.sv
// Handshake and payload bundle between EX/MEM, the MEM/WB stage and the
// register file / forwarding side.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// in the cycle before it. The producer holds payload steady while valid is
// high and ready is low; valid never depends on ready. flush kills the beat
// offered in the same cycle along with everything already held.
interface mem_wb_stage_register_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [XLEN-1:0]       alu_result_in;
  logic [XLEN-1:0]       data_memory_out_in;
  logic [XLEN-1:0]       pc_plus4_in;
  logic [REG_ADDR_W-1:0] instruction_11_7_in;
  logic                  reg_write_in;
  logic                  jump_rd_in;
  logic                  mem_to_reg_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] instruction_11_7_out;
  logic [XLEN-1:0]       wb_data_out;
  logic                  wb_en_out;

  // Pipeline side: drives instructions in and consumes them out.
  modport master (
    output in_valid, flush, alu_result_in, data_memory_out_in, pc_plus4_in,
           instruction_11_7_in, reg_write_in, jump_rd_in, mem_to_reg_in,
           out_ready,
    input  in_ready, out_valid, instruction_11_7_out, wb_data_out, wb_en_out
  );

  // The stage register itself.
  modport slave (
    input  in_valid, flush, alu_result_in, data_memory_out_in, pc_plus4_in,
           instruction_11_7_in, reg_write_in, jump_rd_in, mem_to_reg_in,
           out_ready,
    output in_ready, out_valid, instruction_11_7_out, wb_data_out, wb_en_out
  );

endinterface

// File: rtl/mem_wb_entry_reg.sv
// One held write-back entry with its valid bit. clear takes priority over load.
module mem_wb_entry_reg
  import mem_wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   clear,
  input  entry_t d,
  output entry_t q,
  output logic   valid
);

  // Capture on load, drop the valid bit on clear; payload is left as-is on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage_register.sv
// MEM/WB stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and write-back value selection at capture.
module mem_wb_stage_register
  import mem_wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_wb_stage_register_if.slave  bus,
  output fill_state_t             state_dbg
);

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } entry_t;

  wb_ctrl_t ctrl;
  entry_t   new_entry;
  entry_t   head_d;
  entry_t   head_q;
  logic     head_valid;
  logic     head_load;
  logic     head_clear;
  logic     in_ready_int;
  logic     accept;
  logic     consume;

  assign accept  = bus.in_valid & in_ready_int & ~bus.flush;
  assign consume = head_valid & bus.out_ready;

  // Select the write-back value as the instruction enters the stage.
  always_comb begin
    ctrl = '{reg_write: bus.reg_write_in, jump_rd: bus.jump_rd_in,
             mem_to_reg: bus.mem_to_reg_in};
    new_entry           = '0;
    new_entry.rd        = bus.instruction_11_7_in;
    new_entry.reg_write = ctrl.reg_write;
    case (wb_select(ctrl.mem_to_reg, ctrl.jump_rd))
      SRC_MEM: new_entry.data = bus.data_memory_out_in;
      SRC_PC:  new_entry.data = bus.pc_plus4_in;
      default: new_entry.data = bus.alu_result_in;
    endcase
  end

  mem_wb_entry_reg #(.entry_t(entry_t)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .q     (head_q),
    .valid (head_valid)
  );

  if (SKID_EN) begin : g_skid
    fill_state_t state;
    logic        ready_q;
    entry_t      skid_q;
    logic        skid_valid;
    logic        skid_load;
    logic        skid_clear;

    // Fill-level FSM; in_ready is registered so it never follows out_ready
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= EMPTY;
        ready_q <= 1'b1;
      end else if (bus.flush) begin
        state   <= EMPTY;
        ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) state <= ONE;
          end
          ONE: begin
            if (accept && !consume) begin
              state   <= TWO;
              ready_q <= 1'b0;
            end else if (consume && !accept) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (consume) begin
              state   <= ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state   <= EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end

    // Steer loads/clears: a second entry parks in the skid slot and is
    // promoted to head when the head drains.
    always_comb begin
      head_load  = 1'b0;
      head_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      head_d     = skid_valid ? skid_q : new_entry;
      if (bus.flush) begin
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state)
          EMPTY: head_load = accept;
          ONE: begin
            if (accept && consume) begin
              head_load = 1'b1;
            end else if (accept) begin
              skid_load = 1'b1;
            end else if (consume) begin
              head_clear = 1'b1;
            end
          end
          TWO: begin
            if (consume) begin
              head_load  = 1'b1;
              skid_clear = 1'b1;
            end
          end
          default: begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end

    mem_wb_entry_reg #(.entry_t(entry_t)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (new_entry),
      .q     (skid_q),
      .valid (skid_valid)
    );

    assign in_ready_int = ready_q;
    assign state_dbg    = state;
  end else begin : g_single
    // Single entry: accept whenever the head is free or leaving this cycle.
    always_comb begin
      head_d     = new_entry;
      head_load  = accept;
      head_clear = bus.flush | (consume & ~accept);
    end

    assign in_ready_int = ~head_valid | bus.out_ready;
    assign state_dbg    = head_valid ? ONE : EMPTY;
  end

  assign bus.in_ready             = in_ready_int;
  assign bus.out_valid            = head_valid;
  assign bus.instruction_11_7_out = head_q.rd;
  assign bus.wb_data_out          = head_q.data;
  assign bus.wb_en_out            = head_valid & head_q.reg_write & (head_q.rd != '0);

endmodule

// File: tb/tb_mem_wb_stage_register.sv
// Bench for mem_wb_stage_register: one skid instance and one single-entry
// instance share stimulus; each is compared against a queue model.
module tb_mem_wb_stage_register;
  import mem_wb_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int W    = XLEN + RW + 1;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Driven inputs
  logic            in_valid   = 1'b0;
  logic            flush      = 1'b0;
  logic            out_ready  = 1'b0;
  logic            reg_write  = 1'b0;
  logic            jump_rd    = 1'b0;
  logic            mem_to_reg = 1'b0;
  logic [XLEN-1:0] alu = '0, mem = '0, pc = '0;
  logic [RW-1:0]   rd = '0;

  mem_wb_stage_register_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus_s ();
  mem_wb_stage_register_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus_n ();
  fill_state_t dbg_s, dbg_n;

  assign bus_s.in_valid = in_valid;            assign bus_n.in_valid = in_valid;
  assign bus_s.flush = flush;                  assign bus_n.flush = flush;
  assign bus_s.out_ready = out_ready;          assign bus_n.out_ready = out_ready;
  assign bus_s.alu_result_in = alu;            assign bus_n.alu_result_in = alu;
  assign bus_s.data_memory_out_in = mem;       assign bus_n.data_memory_out_in = mem;
  assign bus_s.pc_plus4_in = pc;               assign bus_n.pc_plus4_in = pc;
  assign bus_s.instruction_11_7_in = rd;       assign bus_n.instruction_11_7_in = rd;
  assign bus_s.reg_write_in = reg_write;       assign bus_n.reg_write_in = reg_write;
  assign bus_s.jump_rd_in = jump_rd;           assign bus_n.jump_rd_in = jump_rd;
  assign bus_s.mem_to_reg_in = mem_to_reg;     assign bus_n.mem_to_reg_in = mem_to_reg;

  mem_wb_stage_register #(.XLEN(XLEN), .REG_ADDR_W(RW), .SKID_EN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .state_dbg(dbg_s));
  mem_wb_stage_register #(.XLEN(XLEN), .REG_ADDR_W(RW), .SKID_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n), .state_dbg(dbg_n));

  // Scoreboard: expected contents of each stage, head first, as {data, rd, reg_write}
  logic [W-1:0]  exp_q_s[$];
  logic [W-1:0]  exp_q_n[$];
  logic [RW-1:0] log_s[$];
  int checks = 0;
  int errors = 0;
  int acc_s = 0, acc_n = 0, out_s = 0, out_n = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] make_entry();
    logic [XLEN-1:0] d;
    d = mem_to_reg ? mem : (jump_rd ? pc : alu);
    return {d, rd, reg_write};
  endfunction

  // Compare one DUT against its model head and expected in_ready
  task automatic check_one(string tag, int sz, logic [W-1:0] head, logic exp_rdy,
                           logic a_rdy, logic a_vld, logic [XLEN-1:0] a_data,
                           logic [RW-1:0] a_rd, logic a_en);
    check({tag, "_in_ready"}, 64'(a_rdy), 64'(exp_rdy));
    check({tag, "_out_valid"}, 64'(a_vld), 64'(sz > 0));
    if (sz > 0) begin
      check({tag, "_wb_data"}, 64'(a_data), 64'(head[W-1 -: XLEN]));
      check({tag, "_rd"}, 64'(a_rd), 64'(head[RW:1]));
      check({tag, "_wb_en"}, 64'(a_en), 64'(head[0] && head[RW:1] != 0));
    end else begin
      check({tag, "_wb_en_idle"}, 64'(a_en), 64'd0);
    end
  endtask

  task automatic check_models();
    logic [W-1:0] hs, hn;
    hs = (exp_q_s.size() > 0) ? exp_q_s[0] : '0;
    hn = (exp_q_n.size() > 0) ? exp_q_n[0] : '0;
    check_one("skid", exp_q_s.size(), hs, exp_q_s.size() < 2, bus_s.in_ready,
              bus_s.out_valid, bus_s.wb_data_out, bus_s.instruction_11_7_out, bus_s.wb_en_out);
    check_one("single", exp_q_n.size(), hn, exp_q_n.size() == 0 || out_ready, bus_n.in_ready,
              bus_n.out_valid, bus_n.wb_data_out, bus_n.instruction_11_7_out, bus_n.wb_en_out);
    if (in_valid && bus_s.in_ready && !flush) acc_s++;
    if (in_valid && bus_n.in_ready && !flush) acc_n++;
    if (bus_s.out_valid && out_ready) begin
      out_s++;
      log_s.push_back(bus_s.instruction_11_7_out);
    end
    if (bus_n.out_valid && out_ready) out_n++;
  endtask

  // Advance the models by one edge: flush empties, else pop the head then
  // push the offered instruction if the stage had room.
  task automatic update_models();
    logic rs, rn;
    logic [W-1:0] e;
    rs = exp_q_s.size() < 2;
    rn = exp_q_n.size() == 0 || out_ready;
    e  = make_entry();
    if (flush) begin
      exp_q_s.delete();
      exp_q_n.delete();
    end else begin
      if (exp_q_s.size() > 0 && out_ready) void'(exp_q_s.pop_front());
      if (exp_q_n.size() > 0 && out_ready) void'(exp_q_n.pop_front());
      if (in_valid && rs) exp_q_s.push_back(e);
      if (in_valid && rn) exp_q_n.push_back(e);
    end
  endtask

  // Called at posedge+1: check mid-cycle, then take the edge
  task automatic cycle();
    #4;
    check_models();
    @(posedge clk);
    update_models();
    #1;
  endtask

  task automatic drive(logic [RW-1:0] r, logic [XLEN-1:0] a);
    in_valid = 1'b1; rd = r; alu = a; mem = ~a; pc = a + 4;
    reg_write = 1'b1; jump_rd = 1'b0; mem_to_reg = 1'b0;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_s_out_valid"}, 64'(bus_s.out_valid), 64'd0);
    check({tag, "_s_wb_en"}, 64'(bus_s.wb_en_out), 64'd0);
    check({tag, "_s_wb_data"}, 64'(bus_s.wb_data_out), 64'd0);
    check({tag, "_s_rd"}, 64'(bus_s.instruction_11_7_out), 64'd0);
    check({tag, "_s_in_ready"}, 64'(bus_s.in_ready), 64'd1);
    check({tag, "_s_state"}, 64'(dbg_s), 64'(EMPTY));
    check({tag, "_n_out_valid"}, 64'(bus_n.out_valid), 64'd0);
    check({tag, "_n_wb_en"}, 64'(bus_n.wb_en_out), 64'd0);
    check({tag, "_n_in_ready"}, 64'(bus_n.in_ready), 64'd1);
  endtask

  typedef struct {
    logic            m2r, jmp, rw;
    logic [XLEN-1:0] a, m, p;
    logic [RW-1:0]   r;
    logic [XLEN-1:0] exp_data;
    logic            exp_en;
  } vec_t;

  vec_t vecs[6];
  logic c_taken;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h104, 5'd5,  32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h104, 5'd1,  32'h104,      1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h104, 5'd31, 32'h10,       1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h20, 32'hCAFE0000, 32'h204, 5'd9,  32'hCAFE0000, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h55, 32'h0,        32'h8,   5'd0,  32'h55,       1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h77, 32'h1,        32'h3C,  5'd7,  32'h3C,       1'b0};

    // Reset
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write-back select and x0 suppression
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_to_reg = vecs[i].m2r; jump_rd = vecs[i].jmp; reg_write = vecs[i].rw;
      alu = vecs[i].a; mem = vecs[i].m; pc = vecs[i].p; rd = vecs[i].r;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_s_valid", i), 64'(bus_s.out_valid), 64'd1);
      check($sformatf("vec%0d_s_data", i), 64'(bus_s.wb_data_out), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_s_en", i), 64'(bus_s.wb_en_out), 64'(vecs[i].exp_en));
      check($sformatf("vec%0d_n_data", i), 64'(bus_n.wb_data_out), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_n_en", i), 64'(bus_n.wb_en_out), 64'(vecs[i].exp_en));
      cycle();
    end

    // Backpressure: A, B held, C stalls, then drain in order
    out_ready = 1'b0;
    log_s.delete();
    drive(5'd10, 32'hA0); cycle();
    drive(5'd11, 32'hB0); cycle();
    #1;
    check("bp_s_in_ready", 64'(bus_s.in_ready), 64'd0);
    check("bp_s_state", 64'(dbg_s), 64'(TWO));
    check("bp_s_head_rd", 64'(bus_s.instruction_11_7_out), 64'd10);
    drive(5'd12, 32'hC0); cycle(); cycle();
    out_ready = 1'b1;
    c_taken = 1'b0;
    for (int i = 0; i < 4 && !c_taken; i++) begin
      c_taken = exp_q_s.size() < 2;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    check("bp_order_len", 64'(log_s.size()), 64'd3);
    if (log_s.size() == 3) begin
      check("bp_order_0", 64'(log_s[0]), 64'd10);
      check("bp_order_1", 64'(log_s[1]), 64'd11);
      check("bp_order_2", 64'(log_s[2]), 64'd12);
    end

    // Flush with two held and a new instruction offered
    out_ready = 1'b0;
    drive(5'd13, 32'hD0); cycle();
    drive(5'd14, 32'hE0); cycle();
    drive(5'd15, 32'hF0); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_s_valid", 64'(bus_s.out_valid), 64'd0);
    check("flush_s_state", 64'(dbg_s), 64'(EMPTY));
    check("flush_n_valid", 64'(bus_n.out_valid), 64'd0);
    check("flush_n_state", 64'(dbg_n), 64'(EMPTY));
    out_ready = 1'b1;
    repeat (2) cycle();

    // Asynchronous reset mid-stream, then first accept after release
    out_ready = 1'b0;
    drive(5'd16, 32'h100); cycle();
    drive(5'd17, 32'h110); cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("mid");
    exp_q_s.delete();
    exp_q_n.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(5'd18, 32'h120);
    cycle();
    in_valid = 1'b0;
    #1;
    check("rel_s_rd", 64'(bus_s.instruction_11_7_out), 64'd18);
    check("rel_n_rd", 64'(bus_n.instruction_11_7_out), 64'd18);
    out_ready = 1'b1;
    cycle();

    // Full throughput with out_ready held high
    acc_s = 0; acc_n = 0; out_s = 0; out_n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(5'($urandom_range(0, 31)), $urandom());
      cycle();
    end
    in_valid = 1'b0;
    check("tput_s_accepts", 64'(acc_s), 64'd20);
    check("tput_n_accepts", 64'(acc_n), 64'd20);
    check("tput_s_outs", 64'(out_s), 64'd19);
    check("tput_n_outs", 64'(out_n), 64'd19);
    cycle();

    // Random streaming against the models
    for (int i = 0; i < 400; i++) begin
      in_valid   = $urandom_range(0, 99) < 70;
      out_ready  = $urandom_range(0, 99) < 60;
      flush      = $urandom_range(0, 99) < 3;
      reg_write  = $urandom_range(0, 1) == 1;
      jump_rd    = $urandom_range(0, 1) == 1;
      mem_to_reg = $urandom_range(0, 1) == 1;
      rd         = 5'($urandom_range(0, 31));
      alu        = $urandom();
      mem        = $urandom();
      pc         = $urandom();
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_register.md
# mem_wb_stage_register

Parametrised MEM/WB pipeline stage register for the segmented RISC-V core, replacing the plain always-advancing MEM/WB latch. It captures the EX/MEM ALU result, data-memory read data, link value, destination register and WB control bits, and adds a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and a built-in write-back select. Sits between the data-memory stage and the register file and forwarding unit.

## Interface

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register-index width
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, in_ready combinational from out_ready

Ports:
- clk  in  1  stage clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream (EX/MEM) holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- flush  in  1  synchronous kill of all held entries
- alu_result_in  in  XLEN  ALU result from EX/MEM
- data_memory_out_in  in  XLEN  data-memory read data
- pc_plus4_in  in  XLEN  link value for JAL/JALR
- instruction_11_7_in  in  REG_ADDR_W  destination register rd
- reg_write_in, jump_rd_in, mem_to_reg_in  in  1 each  WB control
- out_valid  out  1  head entry valid
- out_ready  in  1  register file/downstream consumes head
- instruction_11_7_out  out  REG_ADDR_W  head rd
- wb_data_out  out  XLEN  selected write-back value
- wb_en_out  out  1  out_valid & reg_write & (rd != 0)

## Operation

- Transfer in: in_valid & in_ready & !flush. Transfer out: out_valid & out_ready.
- Write-back select per entry (priority): mem_to_reg → data_memory_out; else jump_rd → pc_plus4; else alu_result. Selection applied at capture; entry stores XLEN data, rd, reg_write.
- SKID_EN=1, FSM on entry count:
  - EMPTY: in → ONE.
  - ONE: in & !out → TWO (new entry to skid); out & !in → EMPTY; in & out → ONE (head replaced).
  - TWO: in_ready=0; out → ONE, skid promoted to head.
  - in_ready = (state != TWO), purely registered.
- SKID_EN=0: one entry; in_ready = !out_valid | out_ready; in & out same cycle replaces head.
- flush: next edge state → EMPTY, all valids 0; simultaneous in_valid is dropped, flush wins over accept and consume.
- Order strictly FIFO; no entry duplicated or lost without flush.
- Data fields of invalid entries are don't-care but must not assert wb_en_out.

## Timing

- Reset (rst_n low, asynchronous): state EMPTY, out_valid=0, wb_en_out=0, wb_data_out=0, instruction_11_7_out=0, in_ready=1.
- Latency: accepted instruction appears on outputs the next cycle when stage was empty or consumed.
- Full throughput: one instruction/cycle with out_ready held high, both modes.
- SKID_EN=1: in_ready has no combinational path from out_ready; deasserts the cycle after the second entry is captured.
- rst_n deasserted mid-stream: first acceptance on first rising edge with rst_n high.
- Outputs stable while out_valid & !out_ready.

## Structure

- Shared package mem_wb_pkg: wb_ctrl_t struct {reg_write, jump_rd, mem_to_reg}, wb_entry_t struct {data, rd, reg_write}, FSM enum {EMPTY, ONE, TWO}, wb_select() function.
- One sub-module: mem_wb_entry_reg (one wb_entry_t plus valid, load/clear), instantiated once or twice by SKID_EN.
- Wiring designator updated to drive the handshake; stall controller drives out_ready.

## Test plan

- Reset: rst_n low mid-stream with entries held → out_valid=0, wb_en_out=0, in_ready=1 immediately.
- Select: mem_to_reg=1, data=0xDEAD_BEEF, alu=0x10 → wb_data_out=0xDEADBEEF; jump_rd=1, pc_plus4=0x104 → 0x104; both 0 → 0x10.
- x0 suppression: rd=0, reg_write=1 → out_valid=1, wb_en_out=0.
- Backpressure (SKID_EN=1): out_ready=0, three in_valid cycles A,B,C → A,B held, in_ready=0 after B, C stalls; out_ready=1 → A,B,C out in order, one per cycle.
- Flush with in_valid=1 and two entries held → next cycle out_valid=0, incoming entry dropped.
- Streaming both modes: 100 random instructions, random out_ready → scoreboard order and values match, no loss; SKID_EN=0 sustains 1/cycle with out_ready=1.
